uart_rx_deserializer: RTL and testbench

// Serial-to-parallel front end of the UART receiver. Samples the asynchronous rx line and

---
 rtl/uart_rx_deserializer.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//
// Serial-to-parallel front end of the UART receiver. The asynchronous rx line
// is synchronised, a start bit is qualified at mid-bit, 8 data bits are
// shifted in LSB-first and the stop bit is checked. A good frame updates data
// and pulses ready for one cycle. A low stop bit pulses frame_err for one
// cycle and discards the byte.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  asynchronous serial line, idle high
//   data       out  8  last correctly framed byte, held until next good frame
//   ready      out  1  one-cycle pulse: data updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1  high while the FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            rx_meta_r;
  logic            rx_s;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            shift_en_s;
  logic            stop_good_s;
  logic            stop_bad_s;
  logic            good_r;
  logic            bad_r;
  logic [7:0]      data_r;
  logic            ready_r;
  logic            frame_err_r;
  logic            busy_r;

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Next-state logic and per-cycle sample strobes.
  always_comb begin
    state_next_s = state_r;
    shift_en_s   = 1'b0;
    stop_good_s  = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        // Mid start bit: a line that has gone high again was only a glitch.
        if (cnt_r == HALF_M1) begin
          if (!rx_s) begin
            state_next_s = DATA;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          shift_en_s = 1'b1;
          if (bit_idx_r == BIT_LAST) begin
            state_next_s = STOP;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        // Leaving here mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_r == FULL_M1) begin
          state_next_s = IDLE;
          if (rx_s) begin
            stop_good_s = 1'b1;
          end else begin
            stop_bad_s  = 1'b1;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Bit-period counter: clears on any state change and at each data bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_next_s != state_r) || (state_r == IDLE)) begin
      cnt_r <= '0;
    end else if ((state_r == DATA) && (cnt_r == FULL_M1)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else if (state_r != DATA) begin
      bit_idx_r <= 3'd0;
      shift_r   <= shift_r;
    end else if (shift_en_s) begin
      bit_idx_r          <= bit_idx_r + 3'd1;
      shift_r[bit_idx_r] <= rx_s;
    end else begin
      bit_idx_r <= bit_idx_r;
      shift_r   <= shift_r;
    end
  end

  // Stop-bit verdict stage followed by the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_r      <= 1'b0;
      bad_r       <= 1'b0;
      data_r      <= 8'h00;
      ready_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      good_r      <= stop_good_s;
      bad_r       <= stop_bad_s;
      ready_r     <= good_r;
      frame_err_r <= bad_r;
      if (good_r) begin
        data_r <= shift_r;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign data      = data_r;
  assign ready     = ready_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed bench for uart_rx_deserializer with CLKS_PER_BIT=16. Inputs are
// driven and outputs sampled on the falling clock edge. A monitor counts
// ready/frame_err pulses and captures the byte and cycle of each ready.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;

  int         ready_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         ready_cyc = 0;
  int         prev_ready_cyc = 0;
  int         ferr_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic [7:0] cap_prev = 8'h00;
  logic       ready_d = 1'b0;
  logic       ferr_d = 1'b0;

  int r0;
  int f0;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .ready     (ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges so far, stable at the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt      <= ready_cnt + 1;
      cap_prev       <= cap_data;
      cap_data       <= data;
      prev_ready_cyc <= ready_cyc;
      ready_cyc      <= cyc;
    end
    if (frame_err === 1'b1) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if ((ready === 1'b1) && (frame_err === 1'b1)) both_cnt <= both_cnt + 1;
    if (((ready === 1'b1) && ready_d) || ((frame_err === 1'b1) && ferr_d)) long_cnt <= long_cnt + 1;
    ready_d <= (ready === 1'b1);
    ferr_d  <= (frame_err === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame starting at a falling edge; returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_data", {24'h0, data}, 32'h00);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // 1. idle line for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outs", {21'h0, data, ready, frame_err, busy}, 32'h0);
    end

    // 2. single frame 8'h33
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    chk("f33_pulses", ready_cnt - r0, 32'd1);
    chk("f33_ferr", ferr_cnt - f0, 32'd0);
    chk("f33_cap", {24'h0, cap_data}, 32'h33);
    chk("f33_data", {24'h0, data}, 32'h33);
    chk("f33_latency", ready_cyc - start_cyc, 32'd156);
    chk("f33_busy", {31'h0, busy}, 32'h0);

    // 3. back-to-back 8'hBB, 8'hA5
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'hBB, 1'b1);
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_pulses", ready_cnt - r0, 32'd2);
    chk("b2b_ferr", ferr_cnt - f0, 32'd0);
    chk("b2b_first", {24'h0, cap_prev}, 32'hBB);
    chk("b2b_second", {24'h0, cap_data}, 32'hA5);
    chk("b2b_spacing", ready_cyc - prev_ready_cyc, 32'd160);
    chk("b2b_latency", ready_cyc - start_cyc, 32'd156);
    chk("b2b_data", {24'h0, data}, 32'hA5);

    // 4. 8'h55 with stop bit low
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("ferr_pulses", ferr_cnt - f0, 32'd1);
    chk("ferr_ready", ready_cnt - r0, 32'd0);
    chk("ferr_latency", ferr_cyc - start_cyc, 32'd156);
    chk("ferr_data", {24'h0, data}, 32'hA5);
    chk("ferr_busy", {31'h0, busy}, 32'h0);

    // 5. 4-cycle glitch, then 8'h0F
    r0 = ready_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_idle", {31'h0, busy}, 32'h0);
    chk("glitch_ready", ready_cnt - r0, 32'd0);
    chk("glitch_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    chk("f0f_pulses", ready_cnt - r0, 32'd1);
    chk("f0f_data", {24'h0, data}, 32'h0F);

    // 6. reset during data bit 4 of 8'hFF, then 8'hC3
    r0 = ready_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_data", {24'h0, data}, 32'h00);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("rstmid_ready", ready_cnt - r0, 32'd0);
    chk("rstmid_ferr", ferr_cnt - f0, 32'd0);
    chk("rstmid_hold", {24'h0, data}, 32'h00);
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    chk("fc3_pulses", ready_cnt - r0, 32'd1);
    chk("fc3_data", {24'h0, data}, 32'hC3);
    chk("fc3_latency", ready_cyc - start_cyc, 32'd156);

    // 7. break: line held low
    r0 = ready_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (400) @(negedge clk);
    chk("break_ferr", ferr_cnt - f0, 32'd2);
    chk("break_ready", ready_cnt - r0, 32'd0);
    chk("break_data", {24'h0, data}, 32'hC3);

    // Pulse-shape invariants over the whole run
    chk("never_both", both_cnt, 32'd0);
    chk("single_cycle", long_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
